// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier sequencer for MUL/MULH/MULHSU/MULHU in the EX stage.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one op in flight at a time.
// Backpressure: stall_fetch holds upstream from request cycle through SIGN; start is ignored while busy/DONE.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_fetch,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplr_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   mcand_ext;
    logic [2*WIDTH-1:0]   prod;

    assign accept = (state_q == IDLE) && start && !flush;

    // Magnitudes are taken only for operands the op treats as signed; the most
    // negative value negates to itself, which is the correct unsigned magnitude.
    assign a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && a[WIDTH-1];
    assign b_neg = (op == OP_MULH) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    assign prod      = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN:    state_d = flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= (state_q == SIGN) && !flush;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        neg_q   <= a_neg ^ b_neg;
                        mcand_q <= a_mag;
                        mplr_q  <= b_mag;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    if (flush) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                    end else begin
                        if (mplr_q[0]) begin
                            acc_q <= acc_q + (mcand_ext << cnt_q);
                        end
                        mplr_q <= mplr_q >> 1;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                SIGN: begin
                    if (flush) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                    end else begin
                        result_q <= (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == CALC) || (state_q == SIGN);
    assign done   = done_q;
    assign result = result_q;

    // Gated by rst_n so fetch is released immediately while reset is asserted.
    assign stall_fetch = rst_n && (accept || busy);

endmodule
